// File: rtl/uart_word_io_pkg.sv
// Shared types and default sizing for the UART word I/O unit.
package uart_word_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } tx_state_t;

    localparam int DEF_WORD_BYTES     = 4;
    localparam int DEF_RX_DEPTH       = 8;
    localparam int DEF_TX_DEPTH       = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/uart_word_io_sync_fifo.sv
// Single-clock FIFO with combinational head read and occupancy count.
// Push acceptance looks only at the registered count, so a same-cycle pop never frees a slot.
module sync_fifo
    import uart_word_io_pkg::*;
#(
    parameter int WIDTH = 8 * DEF_WORD_BYTES,
    parameter int DEPTH = DEF_RX_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset; empty_o qualifies every use of head_o.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_word_io.sv
// UART word I/O: packs RX bytes big-endian into words, serialises TX words MSB byte first.
// Define UART_WORD_IO_TIMEOUT_EN to discard a partial RX word after TIMEOUT_CYCLES idle cycles.
module uart_word_io
    import uart_word_io_pkg::*;
#(
    parameter int WORD_BYTES     = DEF_WORD_BYTES,
    parameter int RX_DEPTH       = DEF_RX_DEPTH,
    parameter int TX_DEPTH       = DEF_TX_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    input  logic [7:0]                  rx_byte,
    input  logic                        rx_byte_valid,
    output logic [7:0]                  tx_byte,
    output logic                        tx_byte_enable,
    input  logic                        tx_ready,
    input  logic                        rd_req,
    output logic [8*WORD_BYTES-1:0]     rd_data,
    output logic                        rd_valid,
    input  logic                        wr_req,
    input  logic [8*WORD_BYTES-1:0]     wr_data,
    output logic                        wr_full,
    output logic                        stall,
    output logic                        rx_overflow,
    input  logic                        err_clear,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic [$clog2(TX_DEPTH):0]   tx_count
);
    localparam int W   = 8 * WORD_BYTES;
    localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int LW  = $clog2(WORD_BYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES - 1);

    if (RX_DEPTH < 2 || TX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 ||
        (TX_DEPTH & (TX_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_word_io: depths must be powers of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // ---------------- RX assembler ----------------
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [W-1:0]   shift_q, shift_d, rx_word, rx_head;
    logic           rx_overflow_q, rx_overflow_d;
    logic           rx_last, rx_full, rx_empty;

    assign rx_last = rx_byte_valid && (byte_cnt_q == LAST_BYTE);
    assign rx_word = (shift_q << 8) | W'(rx_byte);

`ifdef UART_WORD_IO_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);
    logic [IW-1:0] idle_q, idle_d;
    logic          rx_timeout;

    assign rx_timeout = (byte_cnt_q != '0) && (idle_q == IDLE_MAX);

    always_comb begin
        idle_d = idle_q;
        if (rx_byte_valid) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`endif

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (rx_byte_valid) begin
            shift_d    = rx_word;
            byte_cnt_d = rx_last ? '0 : byte_cnt_q + 1'b1;
        end
`ifdef UART_WORD_IO_TIMEOUT_EN
        else if (rx_timeout) begin
            byte_cnt_d = '0;
        end
`endif
    end

    // A completed word that finds the FIFO full sets the flag; setting wins over clearing.
    always_comb begin
        rx_overflow_d = rx_overflow_q;
        if (rx_last && rx_full) begin
            rx_overflow_d = 1'b1;
        end else if (err_clear) begin
            rx_overflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    sync_fifo #(.WIDTH(W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk         (CLK),
        .rst_n       (reset_n),
        .push_i      (rx_last),
        .push_data_i (rx_word),
        .pop_i       (rd_req),
        .head_o      (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .count_o     (rx_count)
    );

    assign rd_valid    = ~rx_empty;
    assign rd_data     = rx_empty ? '0 : rx_head;
    assign rx_overflow = rx_overflow_q;

    // ---------------- TX serialiser ----------------
    tx_state_t      state_q, state_d;
    logic [W-1:0]   tx_word_q, tx_word_d, tx_head;
    logic [LW-1:0]  tx_left_q, tx_left_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic           tx_en_q, tx_en_d, tx_pop, tx_full, tx_empty;

    sync_fifo #(.WIDTH(W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk         (CLK),
        .rst_n       (reset_n),
        .push_i      (wr_req),
        .push_data_i (wr_data),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .count_o     (tx_count)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // GUARD lasts one cycle so the sender's stale ready is never taken as a second grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!tx_empty) state_d = SEND;
            SEND:    if (tx_ready)  state_d = GUARD;
            GUARD:   state_d = (tx_left_q != '0) ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_word_d = tx_word_q;
        tx_left_d = tx_left_q;
        tx_byte_d = tx_byte_q;
        tx_en_d   = 1'b0;
        tx_pop    = 1'b0;
        case (state_q)
            IDLE: if (!tx_empty) begin
                tx_pop    = 1'b1;
                tx_word_d = tx_head;
                tx_left_d = LW'(WORD_BYTES);
            end
            SEND: if (tx_ready) begin
                tx_byte_d = tx_word_q[W-1 -: 8];
                tx_en_d   = 1'b1;
                tx_word_d = tx_word_q << 8;
                tx_left_d = tx_left_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            tx_word_q <= '0;
            tx_left_q <= '0;
            tx_byte_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            tx_word_q <= tx_word_d;
            tx_left_q <= tx_left_d;
            tx_byte_q <= tx_byte_d;
            tx_en_q   <= tx_en_d;
        end
    end

    assign tx_byte        = tx_byte_q;
    assign tx_byte_enable = tx_en_q;
    assign wr_full        = tx_full;
    assign stall          = (rd_req & ~rd_valid) | (wr_req & wr_full);

endmodule

// File: tb/tb_uart_word_io.sv
// Randomised bench for uart_word_io: queue-based RX reference model plus TX byte-stream scoreboard.
module tb_uart_word_io;
    localparam int WB  = 4;
    localparam int W   = 8 * WB;
    localparam int RXD = 2;
    localparam int TXD = 2;
    localparam int TO  = 100;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   rx_byte = '0;
    logic         rx_byte_valid = 1'b0;
    logic [7:0]   tx_byte;
    logic         tx_byte_enable;
    logic         tx_ready = 1'b0;
    logic         rd_req = 1'b0;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         wr_req = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         wr_full;
    logic         stall;
    logic         rx_overflow;
    logic         err_clear = 1'b0;
    logic [1:0]   rx_count;
    logic [1:0]   tx_count;

    always #5 clk = ~clk;

    uart_word_io #(
        .WORD_BYTES(WB), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(clk), .reset_n(reset_n),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .tx_byte(tx_byte), .tx_byte_enable(tx_byte_enable), .tx_ready(tx_ready),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_data(wr_data), .wr_full(wr_full),
        .stall(stall), .rx_overflow(rx_overflow), .err_clear(err_clear),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    logic [W-1:0] rx_q[$];
    logic [7:0]   part[$];
    bit           ovf_m = 1'b0;
    int           idle_m = 0;
    logic [7:0]   exp_tx[$];
    logic [7:0]   got_tx[$];
    int           en_cyc[$];
    logic         prev_en = 1'b0;
    bit           wr_acc = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_byte_enable) begin
            check("tx_en_back_to_back", 64'(prev_en), 64'd0);
            got_tx.push_back(tx_byte);
            en_cyc.push_back(cyc);
        end
        prev_en <= tx_byte_enable;
    end

    // Reference: bytes gather into a big-endian word; a word joins the queue only if
    // the queue held fewer than RXD entries before this cycle's pop.
    task automatic model_update();
        int           sz;
        logic [W-1:0] word;
        bit           push_ok;
        bit           set_ovf;
        sz = rx_q.size();
        word = '0;
        push_ok = 1'b0;
        set_ovf = 1'b0;
`ifdef UART_WORD_IO_TIMEOUT_EN
        if (rx_byte_valid) idle_m = 0;
        else begin
            idle_m++;
            if (idle_m > TO) part.delete();
        end
`endif
        if (rx_byte_valid) begin
            part.push_back(rx_byte);
            if (part.size() == WB) begin
                foreach (part[i]) word = (word << 8) | W'(part[i]);
                part.delete();
                if (sz < RXD) push_ok = 1'b1;
                else          set_ovf = 1'b1;
            end
        end
        if (rd_req && sz > 0) void'(rx_q.pop_front());
        if (push_ok) rx_q.push_back(word);
        if (set_ovf)        ovf_m = 1'b1;
        else if (err_clear) ovf_m = 1'b0;
    endtask

    // One clock: pre-edge stall sampling, edge, model update, post-edge comparison.
    task automatic step();
        logic         st;
        logic [W-1:0] exp_head;
        #1;
        st = stall;
        if (rd_req && !wr_req) check("stall_rd", 64'(st), 64'(rx_q.size() == 0));
        wr_acc = wr_req && !st;
        if (wr_acc) for (int i = WB - 1; i >= 0; i--) exp_tx.push_back(wr_data[8*i +: 8]);
        @(posedge clk);
        model_update();
        #1;
        exp_head = '0;
        if (rx_q.size() > 0) exp_head = rx_q[0];
        check("rd_valid", 64'(rd_valid), 64'(rx_q.size() > 0));
        check("rd_data", 64'(rd_data), 64'(exp_head));
        check("rx_count", 64'(rx_count), 64'(rx_q.size()));
        check("rx_overflow", 64'(rx_overflow), 64'(ovf_m));
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_byte = b;
        rx_byte_valid = 1'b1;
        step();
        rx_byte_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rx_byte_valid = 1'b0; rd_req = 1'b0; wr_req = 1'b0; err_clear = 1'b0; tx_ready = 1'b0;
        rx_q.delete(); part.delete(); ovf_m = 1'b0; idle_m = 0;
        exp_tx.delete(); got_tx.delete(); en_cyc.delete();
        #2;
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_wr_full", 64'(wr_full), 64'd0);
        check("rst_tx_en", 64'(tx_byte_enable), 64'd0);
        check("rst_tx_byte", 64'(tx_byte), 64'd0);
        check("rst_overflow", 64'(rx_overflow), 64'd0);
        check("rst_rx_count", 64'(rx_count), 64'd0);
        check("rst_tx_count", 64'(tx_count), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic tx_drain(input string tag);
        int g;
        g = 0;
        while (got_tx.size() < exp_tx.size() && g < 400) begin
            step();
            g++;
        end
        repeat (6) step();
        check({tag, "_nbytes"}, 64'(got_tx.size()), 64'(exp_tx.size()));
        foreach (exp_tx[i]) if (i < got_tx.size()) check({tag, "_byte"}, 64'(got_tx[i]), 64'(exp_tx[i]));
        check({tag, "_tx_count"}, 64'(tx_count), 64'd0);
        exp_tx.delete(); got_tx.delete(); en_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w[4];
        logic [W-1:0] cb;
        int           k;
        int           g;

        apply_reset();

        // Big-endian packing and single-word pop
        rx_send(8'h12); rx_send(8'h34); rx_send(8'h56); rx_send(8'h78);
        check("pack_valid", 64'(rd_valid), 64'd1);
        check("pack_data", 64'(rd_data), 64'h12345678);
        rd_req = 1'b1; step(); rd_req = 1'b0;
        check("pack_popped", 64'(rd_valid), 64'd0);

        // Overflow with a two-entry RX FIFO
        for (int n = 0; n < 3; n++) begin
            w[n] = $urandom;
            for (int i = WB - 1; i >= 0; i--) rx_send(w[n][8*i +: 8]);
        end
        check("ovf_count", 64'(rx_count), 64'd2);
        check("ovf_flag", 64'(rx_overflow), 64'd1);
        check("ovf_head", 64'(rd_data), 64'(w[0]));
        err_clear = 1'b1; step(); err_clear = 1'b0;
        check("ovf_cleared", 64'(rx_overflow), 64'd0);
        rd_req = 1'b1; repeat (3) step(); rd_req = 1'b0;

        // Random RX traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            rx_byte       = 8'($urandom);
            rx_byte_valid = ($urandom_range(0, 1) == 1);
            rd_req        = ($urandom_range(0, 9) < 3);
            err_clear     = ($urandom_range(0, 19) == 0);
            step();
        end
        rx_byte_valid = 1'b0; rd_req = 1'b0; err_clear = 1'b0;

        // Reset mid-word discards the partial word
        rx_send(8'($urandom)); rx_send(8'($urandom));
        apply_reset();
        rx_send(8'hAA); rx_send(8'hBB); rx_send(8'hCC); rx_send(8'hDD);
        check("reset_midword", 64'(rd_data), 64'hAABBCCDD);
        rd_req = 1'b1; step(); rd_req = 1'b0;

`ifdef UART_WORD_IO_TIMEOUT_EN
        rx_send(8'h55);
        repeat (150) step();
        rx_send(8'h01); rx_send(8'h02); rx_send(8'h03); rx_send(8'h04);
        check("timeout_word", 64'(rd_data), 64'h01020304);
        rd_req = 1'b1; step(); rd_req = 1'b0;
`endif

        // TX serialisation latency and spacing
        exp_tx.delete(); got_tx.delete(); en_cyc.delete();
        tx_ready = 1'b1;
        cb = 32'hCAFEBABE;
        wr_data = cb; wr_req = 1'b1; k = cyc;
        step();
        wr_req = 1'b0;
        repeat (12) step();
        check("tx_pulses", 64'(got_tx.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_tx.size()) begin
                check("tx_byte_value", 64'(got_tx[i]), 64'(cb[8*(3-i) +: 8]));
                check("tx_byte_cycle", 64'(en_cyc[i]), 64'(k + 3 + 2*i));
            end
        end
        exp_tx.delete(); got_tx.delete(); en_cyc.delete();

        // Full TX FIFO holds off the third queued write until the sender drains
        tx_ready = 1'b0;
        for (int n = 0; n < 4; n++) w[n] = $urandom;
        wr_data = w[0]; wr_req = 1'b1; step(); wr_req = 1'b0;
        step(); step();
        wr_data = w[1]; wr_req = 1'b1; step();
        wr_data = w[2]; step();
        wr_data = w[3];
        #1;
        check("full_stall", 64'(stall), 64'd1);
        check("full_flag", 64'(wr_full), 64'd1);
        repeat (3) step();
        check("full_held_count", 64'(tx_count), 64'(TXD));
        tx_ready = 1'b1;
        g = 0;
        while (!wr_acc && g < 60) begin
            step();
            g++;
        end
        check("full_write_accepted", 64'(wr_acc), 64'd1);
        wr_req = 1'b0;
        check("full_words_queued", 64'(exp_tx.size()), 64'(4 * WB));
        tx_drain("full");

        // Random TX traffic with random sender pacing
        wr_acc = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tx_ready = ($urandom_range(0, 1) == 1);
            if (!wr_req || wr_acc) begin
                wr_req  = ($urandom_range(0, 9) < 4);
                wr_data = $urandom;
            end
            step();
        end
        wr_req = 1'b0;
        tx_ready = 1'b1;
        tx_drain("rand_tx");
        check("end_wr_full", 64'(wr_full), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_word_io.md
# uart_word_io

Parametrised UART word I/O unit between the byte-level `receiver`/`sender` pair and the CPU pipeline. It replaces the fixed 32-bit, single-entry receive and send buffers:
- **Receive side:** packs incoming bytes into words of configurable width and queues them in an RX FIFO.
- **Transmit side:** queues words from the pipeline in a TX FIFO and serialises them MSB byte first.
- **Pipeline stall:** raises `stall` whenever a read finds the RX FIFO empty or a write finds the TX FIFO full.

## Interface
Parameters:
- `WORD_BYTES`, 4: bytes per word; word width W = 8*WORD_BYTES.
- `RX_DEPTH`, 8: RX FIFO entries; power of two, ≥2.
- `TX_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 1000000: idle cycles after which a partial RX word is discarded (used only with the macro).

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `rx_byte`  in  8  byte from `receiver`.
- `rx_byte_valid`  in  1  one-cycle strobe; `rx_byte` is valid.
- `tx_byte`  out  8  byte to `sender`.
- `tx_byte_enable`  out  1  one-cycle send strobe to `sender`.
- `tx_ready`  in  1  `sender` idle.
- `rd_req`  in  1  pipeline reads one word (UART-to-register).
- `rd_data`  out  W  RX FIFO head word; reads 0 when the FIFO is empty.
- `rd_valid`  out  1  RX FIFO non-empty.
- `wr_req`  in  1  pipeline writes one word (register-to-UART).
- `wr_data`  in  W  word to send.
- `wr_full`  out  1  TX FIFO full.
- `stall`  out  1  `(rd_req & ~rd_valid) | (wr_req & wr_full)`; combinational.
- `rx_overflow`  out  1  sticky: a completed RX word was dropped.
- `err_clear`  in  1  clears `rx_overflow`.
- `rx_count`  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- `tx_count`  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.

## Operation
- **RX assembler:**
  - A byte counter runs 0..WORD_BYTES-1, alongside a W-bit shift register.
  - The first byte received lands in bits [W-1:W-8], i.e. big-endian.
  - On the edge that samples the last byte, the word is pushed if `rx_count < RX_DEPTH`. Otherwise the word is dropped and `rx_overflow` is set.
  - The counter always returns to 0 after the last byte.
- **Full-FIFO rule (both FIFOs):** a push is accepted only if the registered count is below depth at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
- **RX pop:** occurs when `rd_req & rd_valid`. `rd_req` on an empty FIFO does nothing except raise `stall`.
- **TX push:** occurs when `wr_req & ~wr_full`. A refused write is held off by `stall`; the block never drops it silently.
- **TX serialiser FSM:**
  - IDLE: if `tx_count != 0`, load the head word, pop it, and go to SEND.
  - SEND: if `tx_ready`, register `tx_byte` = the current MSB byte and `tx_byte_enable` = 1, shift left by 8, and go to GUARD. Otherwise stay in SEND.
  - GUARD: `tx_byte_enable` = 0. This state covers exactly one cycle, masking the stale `tx_ready`. Then go to SEND if bytes remain, else IDLE.
- **`rx_overflow` priority:** set beats `err_clear` when both occur in the same cycle.
- **Reset (asynchronous, `reset_n` = 0):**
  - Both FIFOs are emptied and all counters are 0.
  - The FSM goes to IDLE.
  - `tx_byte` = 0, `tx_byte_enable` = 0, `rx_overflow` = 0.
  - The partial word is discarded.
  - Therefore `rd_valid` = 0, `rd_data` = 0 and `wr_full` = 0.
  - Asserting reset mid-byte or mid-word aborts it; no partial byte is emitted afterwards.

## Timing
- **RX latency:** a word whose last byte is strobed in cycle t shows `rd_valid` = 1 in cycle t+1.
- **TX latency:** a word written in cycle t (FIFO previously empty, `tx_ready` = 1):
  - The FSM loads it at t+1.
  - The first `tx_byte_enable` is high in cycle t+3.
  - Each following byte is at least 2 cycles later, and is otherwise paced by `tx_ready`.
- **Registered outputs:** `tx_byte_enable` is registered and is never high in two consecutive cycles.
- **Combinational outputs:** `rd_data`, `rd_valid`, `wr_full` and the counts come straight from registered state. `stall` is combinational from `rd_req`/`wr_req`.

## Configuration
- `UART_WORD_IO_TIMEOUT_EN` defined:
  - An idle counter of width $clog2(TIMEOUT_CYCLES+1) resets on every `rx_byte_valid`.
  - If the RX byte counter is non-zero and the idle counter reaches TIMEOUT_CYCLES, the partial word is discarded and the byte counter returns to 0. Nothing is pushed and `rx_overflow` is unchanged.
- Undefined: no timeout logic; a partial word waits indefinitely.

## Structure
- **Package `uart_word_io_pkg`:**
  - `tx_state_t` enum {IDLE, SEND, GUARD}.
  - Default constants for WORD_BYTES, depths and TIMEOUT_CYCLES.
- **Sub-module `sync_fifo`:** parameters WIDTH and DEPTH; count output, combinational head read, and the registered-count full rule. It is instantiated twice, once for RX and once for TX.

## Test plan
- **RX packing:** with WORD_BYTES=4, strobe 0x12, 0x34, 0x56, 0x78. The next cycle must show `rd_valid` = 1 and `rd_data` = 0x12345678. Then `rd_req` pops it and `rd_valid` returns to 0.
- **RX overflow:** with RX_DEPTH=2, complete 3 words and never read. Required: `rx_count` = 2, `rx_overflow` = 1, head = first word. Then `err_clear` → `rx_overflow` = 0.
- **TX serialisation:** write 0xCAFEBABE with `tx_ready` held 1. Required: 4 enable pulses carrying 0xCA, 0xFE, 0xBA, 0xBE, each 2 cycles apart, with the first in cycle t+3.
- **Full FIFO:** with TX_DEPTH=2, write 3 words while `tx_ready` = 0. Required: `stall` = 1 on the third write, `wr_full` = 1, and no word lost after `tx_ready` rises.
- **Reset mid-word:** receive 2 bytes, pulse `reset_n` low, then receive 4 bytes 0xAA..0xDD. Required: `rd_data` = 0xAABBCCDD.
- **Timeout (`UART_WORD_IO_TIMEOUT_EN`, TIMEOUT_CYCLES=100):** 1 byte, idle 150 cycles, then 4 bytes 0x01..0x04. Required: `rd_data` = 0x01020304.
